load_queue: RTL and testbench
=============================

Name: load_queue

Overview:
- Load-side counterpart to the store buffer: buffers issued loads in program order and resolves each one.
- Each load is first looked up in the store buffer via its search port (store-to-load forwarding). On a miss, the load reads data memory.
- Results return tagged with the ROB index on a single writeback port.
- Sits between dispatch, the store buffer search port, data memory and the common data bus.

Parameters:
- DEPTH, 4, number of load queue entries (power of two, at least 2).
- TAG_W, 4, ROB tag width.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- flush  in  1  branch mispredict flush; sampled on posedge, same effect as reset on queue state.
- ld_valid  in  1  enqueue a load this cycle.
- ld_addr  in  16  load address.
- ld_tag  in  TAG_W  ROB tag of the load.
- ld_stall  out  1  queue full; dispatch must not assert ld_valid.
- sb_search_location  out  16  address driven to the store buffer search port.
- sb_search_data  in  16  forwarded data, combinational from the store buffer.
- sb_search_valid  in  1  store buffer hit.
- mem_rd_req  out  1  memory read request, one-cycle pulse.
- mem_rd_addr  out  16  memory read address.
- mem_rd_data  in  16  memory read data.
- mem_rd_valid  in  1  read data valid; arbitrary latency of 1 or more cycles after mem_rd_req.
- wb_valid  out  1  result valid, one-cycle pulse.
- wb_data  out  16  load result.
- wb_tag  out  TAG_W  ROB tag of the result.

Behaviour:
- Circular FIFO with head/tail pointers of PTR_W+1 bits. full = pointers equal except MSB; empty = pointers fully equal.
- ld_stall = full, combinational. An ld_valid while full is ignored.
- sb_search_location = head entry address whenever the queue is non-empty, otherwise 0.
- FSM states: IDLE, SEARCH, MEM_WAIT, DRAIN.
  - IDLE: when not empty, go to SEARCH.
  - SEARCH (1 cycle):
    - sb_search_valid=1: register wb_valid=1, wb_data=sb_search_data, wb_tag=head tag; pop head; next state IDLE.
    - sb_search_valid=0: pulse mem_rd_req with mem_rd_addr=head address; next state MEM_WAIT.
  - MEM_WAIT: on mem_rd_valid, register wb_valid=1, wb_data=mem_rd_data, wb_tag=head tag; pop head; next state IDLE.
  - DRAIN: entered when flush occurs in MEM_WAIT. Discard the next mem_rd_valid without writeback, then go to IDLE. Enqueues are accepted while in DRAIN.
- Best-case latency, enqueue to wb_valid: 2 cycles on a forward hit (enqueue edge, then SEARCH edge registers the result). Miss latency = 2 + memory latency.
- Only one load is outstanding at a time; results are in order.
- Simultaneous enqueue and pop in one cycle is legal, including when full: the pop frees a slot, but ld_stall still reflects full for that cycle.
- Pointers wrap modulo DEPTH.
- flush:
  - Empties the queue (head=tail=0) and suppresses wb_valid for that cycle.
  - State becomes IDLE, or DRAIN if it was MEM_WAIT or the cycle also issued mem_rd_req.
  - ld_valid in a flush cycle is dropped.
- reset: head=tail=0, state IDLE, wb_valid=0, wb_data=0, wb_tag=0, mem_rd_req=0, mem_rd_addr=0. Reset overrides flush and discards any in-flight memory response (a mem_rd_valid after reset in IDLE is ignored).

Optional Feature:
- Macro LOAD_QUEUE_PERF_CNT_EN.
- When defined: adds outputs perf_fwd_cnt (16 bits) and perf_mem_cnt (16 bits).
  - perf_fwd_cnt increments on each forwarded writeback; perf_mem_cnt increments on each memory writeback.
  - Both saturate at 16'hFFFF, clear on reset, and are unaffected by flush.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, SEARCH=1, MEM_WAIT=2, DRAIN=3), address/data width constant 16, TAG_W default.
- One natural sub-module, load_queue_fifo: entry storage, pointers, full/empty, push/pop. The FSM and writeback logic stay in load_queue.

Test Plan:
- Forward hit: enqueue addr 16'h0040, tag 3; store buffer returns hit with data 16'hBEEF -> wb_valid 2 cycles later with data 16'hBEEF, tag 3; no mem_rd_req.
- Miss: enqueue 16'h0080, tag 5; sb miss; memory returns 16'h1234 after 3 cycles -> one mem_rd_req with addr 16'h0080; wb data 16'h1234, tag 5 the cycle after mem_rd_valid.
- Full/ordering: enqueue 4 loads with tags 1-4 back-to-back -> ld_stall=1 after the 4th; a 5th ld_valid is ignored; writebacks come in tag order 1,2,3,4; ld_stall clears after the first pop.
- Flush in MEM_WAIT: a miss is pending and flush is asserted -> queue empty; the late mem_rd_valid produces no wb_valid; a new load enqueued during DRAIN completes normally after it.
- Reset mid-operation: reset with 2 loads queued -> all outputs 0 the next cycle, ld_stall=0, no writebacks.
- With LOAD_QUEUE_PERF_CNT_EN: 2 hits and 1 miss -> perf_fwd_cnt=2, perf_mem_cnt=1; the counts persist across a flush.

Source files
------------

// File: rtl/load_queue_pkg.sv
// load_queue_pkg: shared types and constants for the load queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, address/data width, default ROB tag width, saturating counter helper.
package load_queue_pkg;

    localparam int LQ_DATA_W = 16;  // address and data width
    localparam int LQ_TAG_W  = 4;   // default ROB tag width

    typedef enum logic [1:0] {
        LQ_IDLE     = 2'd0,
        LQ_SEARCH   = 2'd1,
        LQ_MEM_WAIT = 2'd2,
        LQ_DRAIN    = 2'd3
    } lq_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/load_queue_fifo.sv
// load_queue_fifo: circular entry store (address + ROB tag) for pending loads.
// Latency: push visible at head one cycle after the push edge; head is combinational.
// Backpressure: push refused when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: clk, reset (sync, active-high), clear (empties queue), push/push_addr/push_tag,
//        push_acc (push actually taken), pop, head_addr/head_tag, full, empty.
module load_queue_fifo
    import load_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = LQ_TAG_W,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic [LQ_DATA_W-1:0] push_addr,
    input  logic [TAG_W-1:0]     push_tag,
    output logic                 push_acc,
    input  logic                 pop,
    output logic [LQ_DATA_W-1:0] head_addr,
    output logic [TAG_W-1:0]     head_tag,
    output logic                 full,
    output logic                 empty
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [LQ_DATA_W-1:0] addr_mem [DEPTH];
    logic [TAG_W-1:0]     tag_mem  [DEPTH];
    logic [PTR_W:0]       head;
    logic [PTR_W:0]       tail;
    logic                 pop_acc;

    // Extra MSB on the pointers distinguishes full from empty.
    assign full  = (head[PTR_W] != tail[PTR_W]) && (head[PTR_W-1:0] == tail[PTR_W-1:0]);
    assign empty = (head == tail);

    assign pop_acc  = pop && !empty;
    // A same-cycle pop frees the slot the push lands in.
    assign push_acc = push && (!full || pop_acc);

    assign head_addr = addr_mem[head[PTR_W-1:0]];
    assign head_tag  = tag_mem[head[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_acc) begin
            addr_mem[tail[PTR_W-1:0]] <= push_addr;
            tag_mem[tail[PTR_W-1:0]]  <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push_acc) tail <= tail + PTR_ONE;
            if (pop_acc)  head <= head + PTR_ONE;
        end
    end

endmodule

// File: rtl/load_queue.sv
// load_queue: in-order load buffer; each head load tries store-buffer forwarding, else reads memory.
// Latency: enqueue to wb_valid is 2 cycles on a forward hit, 2 + memory latency on a miss.
// Backpressure: ld_stall (= full) holds off dispatch; one load outstanding to memory at a time.
// Ports: clk, reset, flush, ld_valid/ld_addr/ld_tag/ld_stall (dispatch), sb_search_location/
//        sb_search_data/sb_search_valid (store buffer), mem_rd_* (data memory), wb_* (result bus).
// Optional: define LOAD_QUEUE_PERF_CNT_EN to add perf_fwd_cnt / perf_mem_cnt saturating counters.
module load_queue
    import load_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = LQ_TAG_W,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 ld_valid,
    input  logic [LQ_DATA_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]     ld_tag,
    output logic                 ld_stall,
    output logic [LQ_DATA_W-1:0] sb_search_location,
    input  logic [LQ_DATA_W-1:0] sb_search_data,
    input  logic                 sb_search_valid,
    output logic                 mem_rd_req,
    output logic [LQ_DATA_W-1:0] mem_rd_addr,
    input  logic [LQ_DATA_W-1:0] mem_rd_data,
    input  logic                 mem_rd_valid,
`ifdef LOAD_QUEUE_PERF_CNT_EN
    output logic [15:0]          perf_fwd_cnt,
    output logic [15:0]          perf_mem_cnt,
`endif
    output logic                 wb_valid,
    output logic [LQ_DATA_W-1:0] wb_data,
    output logic [TAG_W-1:0]     wb_tag
);

    lq_state_e            state;
    lq_state_e            state_nxt;
    logic                 push;
    logic                 push_acc;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [LQ_DATA_W-1:0] head_addr;
    logic [TAG_W-1:0]     head_tag;
    logic                 fwd_hit;
    logic                 mem_issue;
    logic                 mem_done;

    load_queue_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_addr (ld_addr),
        .push_tag  (ld_tag),
        .push_acc  (push_acc),
        .pop       (pop),
        .head_addr (head_addr),
        .head_tag  (head_tag),
        .full      (full),
        .empty     (empty)
    );

    assign ld_stall           = full;
    assign sb_search_location = empty ? '0 : head_addr;

    assign fwd_hit   = (state == LQ_SEARCH) && !empty && sb_search_valid;
    assign mem_issue = (state == LQ_SEARCH) && !empty && !sb_search_valid;
    assign mem_done  = (state == LQ_MEM_WAIT) && mem_rd_valid;

    // A flush clears the queue, so neither the dropped enqueue nor the pop must touch it.
    assign push = ld_valid && !flush;
    assign pop  = (fwd_hit || mem_done) && !flush;

    assign mem_rd_req  = mem_issue;
    assign mem_rd_addr = mem_issue ? head_addr : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            // Counting the incoming push lets a load reach SEARCH the cycle after it is enqueued.
            LQ_IDLE:     if (!empty || push_acc) state_nxt = LQ_SEARCH;
            LQ_SEARCH:   state_nxt = mem_issue ? LQ_MEM_WAIT : LQ_IDLE;
            LQ_MEM_WAIT: if (mem_rd_valid) state_nxt = LQ_IDLE;
            LQ_DRAIN:    if (mem_rd_valid) state_nxt = LQ_IDLE;
            default:     state_nxt = LQ_IDLE;
        endcase
        // Drain only while a memory response is still owed; a response arriving in the
        // flush cycle itself already closes the transaction.
        if (flush) begin
            if (mem_issue ||
                ((state == LQ_MEM_WAIT || state == LQ_DRAIN) && !mem_rd_valid))
                state_nxt = LQ_DRAIN;
            else
                state_nxt = LQ_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LQ_IDLE;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_tag   <= '0;
        end else begin
            state    <= state_nxt;
            wb_valid <= 1'b0;
            if (fwd_hit && !flush) begin
                wb_valid <= 1'b1;
                wb_data  <= sb_search_data;
                wb_tag   <= head_tag;
            end else if (mem_done && !flush) begin
                wb_valid <= 1'b1;
                wb_data  <= mem_rd_data;
                wb_tag   <= head_tag;
            end
        end
    end

`ifdef LOAD_QUEUE_PERF_CNT_EN
    // Counts follow writebacks only; flush leaves accumulated values intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fwd_cnt <= '0;
            perf_mem_cnt <= '0;
        end else begin
            if (fwd_hit && !flush)  perf_fwd_cnt <= sat_inc16(perf_fwd_cnt);
            if (mem_done && !flush) perf_mem_cnt <= sat_inc16(perf_mem_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_load_queue.sv
// tb_load_queue: directed bench for load_queue with hand-computed expectations.
// Latency: n/a (bench).
// Backpressure: n/a (bench drives store buffer and memory responses directly).
module tb_load_queue;

    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [TAG_W-1:0] ld_tag;
    logic        ld_stall;
    logic [15:0] sb_search_location;
    logic [15:0] sb_search_data;
    logic        sb_search_valid;
    logic        mem_rd_req;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [TAG_W-1:0] wb_tag;
`ifdef LOAD_QUEUE_PERF_CNT_EN
    logic [15:0] perf_fwd_cnt;
    logic [15:0] perf_mem_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_queue #(.DEPTH(4), .TAG_W(TAG_W), .PTR_W(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .ld_valid           (ld_valid),
        .ld_addr            (ld_addr),
        .ld_tag             (ld_tag),
        .ld_stall           (ld_stall),
        .sb_search_location (sb_search_location),
        .sb_search_data     (sb_search_data),
        .sb_search_valid    (sb_search_valid),
        .mem_rd_req         (mem_rd_req),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_data        (mem_rd_data),
        .mem_rd_valid       (mem_rd_valid),
`ifdef LOAD_QUEUE_PERF_CNT_EN
        .perf_fwd_cnt       (perf_fwd_cnt),
        .perf_mem_cnt       (perf_mem_cnt),
`endif
        .wb_valid           (wb_valid),
        .wb_data            (wb_data),
        .wb_tag             (wb_tag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_tag = '0;
        sb_search_valid = 1'b0; sb_search_data = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
        step(); step();
        reset = 1'b0;
        #1;
        // ---- reset state ----
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_stall", ld_stall, 0);
        chk("rst_req", mem_rd_req, 0);
        chk("rst_mem_addr", mem_rd_addr, 0);
        chk("rst_loc", sb_search_location, 0);

        // ---- forward hit ----
        ld_valid = 1'b1; ld_addr = 16'h0040; ld_tag = 4'd3;
        sb_search_valid = 1'b1; sb_search_data = 16'hBEEF;
        step();
        ld_valid = 1'b0;
        #1;
        chk("hit_loc", sb_search_location, 16'h0040);
        chk("hit_noreq", mem_rd_req, 0);
        chk("hit_wb_early", wb_valid, 0);
        step();
        chk("hit_wb_valid", wb_valid, 1);
        chk("hit_wb_data", wb_data, 16'hBEEF);
        chk("hit_wb_tag", wb_tag, 3);
        sb_search_valid = 1'b0;
        step();
        chk("hit_wb_pulse", wb_valid, 0);
        chk("hit_noreq_after", mem_rd_req, 0);

        // ---- miss, memory latency 3 ----
        ld_valid = 1'b1; ld_addr = 16'h0080; ld_tag = 4'd5;
        step();
        ld_valid = 1'b0;
        #1;
        chk("miss_req", mem_rd_req, 1);
        chk("miss_addr", mem_rd_addr, 16'h0080);
        step();
        chk("miss_req_pulse", mem_rd_req, 0);
        step();
        step();
        mem_rd_valid = 1'b1; mem_rd_data = 16'h1234;
        #1;
        chk("miss_wb_early", wb_valid, 0);
        step();
        mem_rd_valid = 1'b0;
        chk("miss_wb_valid", wb_valid, 1);
        chk("miss_wb_data", wb_data, 16'h1234);
        chk("miss_wb_tag", wb_tag, 5);
        step();
        chk("miss_wb_pulse", wb_valid, 0);

        // ---- full / ordering ----
        for (int i = 1; i <= 4; i++) begin
            ld_valid = 1'b1; ld_addr = 16'(16'h00FF + i); ld_tag = 4'(i);
            step();
        end
        chk("full_stall", ld_stall, 1);
        ld_valid = 1'b1; ld_addr = 16'h01FF; ld_tag = 4'd5;
        step();
        ld_valid = 1'b0;
        chk("full_stall_hold", ld_stall, 1);
        mem_rd_valid = 1'b1; mem_rd_data = 16'hA001;
        step();
        mem_rd_valid = 1'b0;
        sb_search_valid = 1'b1; sb_search_data = 16'hB00B;
        #1;
        chk("ord_wb1_valid", wb_valid, 1);
        chk("ord_wb1_tag", wb_tag, 1);
        chk("ord_wb1_data", wb_data, 16'hA001);
        chk("ord_stall_clear", ld_stall, 0);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("ord_loc", sb_search_location, 32'(16'h00FF + k));
            step();
            chk("ord_wb_valid", wb_valid, 1);
            chk("ord_wb_tag", wb_tag, 32'(k));
            chk("ord_wb_data", wb_data, 16'hB00B);
        end
        step();
        chk("fifth_dropped_wb", wb_valid, 0);
        chk("fifth_dropped_loc", sb_search_location, 0);
        sb_search_valid = 1'b0;

        // ---- flush in MEM_WAIT ----
        ld_valid = 1'b1; ld_addr = 16'h0200; ld_tag = 4'd6;
        step();
        ld_valid = 1'b0;
        #1;
        chk("fl_req", mem_rd_req, 1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_empty_loc", sb_search_location, 0);
        chk("fl_stall", ld_stall, 0);
        chk("fl_wb", wb_valid, 0);
        ld_valid = 1'b1; ld_addr = 16'h0300; ld_tag = 4'd7;
        step();
        ld_valid = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 16'hDEAD;
        #1;
        chk("drain_loc", sb_search_location, 16'h0300);
        chk("drain_noreq", mem_rd_req, 0);
        step();
        mem_rd_valid = 1'b0;
        chk("drain_nowb", wb_valid, 0);
        sb_search_valid = 1'b1; sb_search_data = 16'h7777;
        step();
        chk("drain_next_loc", sb_search_location, 16'h0300);
        chk("drain_next_noreq", mem_rd_req, 0);
        step();
        chk("drain_next_wb", wb_valid, 1);
        chk("drain_next_data", wb_data, 16'h7777);
        chk("drain_next_tag", wb_tag, 7);
        sb_search_valid = 1'b0;
        step();

        // ---- reset mid-operation ----
        ld_valid = 1'b1; ld_addr = 16'h0400; ld_tag = 4'd8;
        step();
        ld_addr = 16'h0401; ld_tag = 4'd9;
        step();
        ld_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_wb_data", wb_data, 0);
        chk("mid_rst_wb_tag", wb_tag, 0);
        chk("mid_rst_req", mem_rd_req, 0);
        chk("mid_rst_addr", mem_rd_addr, 0);
        chk("mid_rst_loc", sb_search_location, 0);
        chk("mid_rst_stall", ld_stall, 0);
        mem_rd_valid = 1'b1; mem_rd_data = 16'h5555;
        step();
        mem_rd_valid = 1'b0;
        chk("mid_rst_late_wb", wb_valid, 0);
        step();
        chk("mid_rst_idle_wb", wb_valid, 0);
        chk("mid_rst_idle_loc", sb_search_location, 0);

        // ---- two hits and one miss, then flush ----
        sb_search_valid = 1'b1; sb_search_data = 16'h1111;
        ld_valid = 1'b1; ld_addr = 16'h0500; ld_tag = 4'd10;
        step();
        ld_valid = 1'b0;
        step();
        chk("p_hit1_tag", wb_tag, 10);
        ld_valid = 1'b1; ld_addr = 16'h0501; ld_tag = 4'd11;
        step();
        ld_valid = 1'b0;
        step();
        chk("p_hit2_tag", wb_tag, 11);
        chk("p_hit2_valid", wb_valid, 1);
        sb_search_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 16'h0502; ld_tag = 4'd12;
        step();
        ld_valid = 1'b0;
        step();
        mem_rd_valid = 1'b1; mem_rd_data = 16'h6666;
        step();
        mem_rd_valid = 1'b0;
        chk("p_miss_valid", wb_valid, 1);
        chk("p_miss_data", wb_data, 16'h6666);
        chk("p_miss_tag", wb_tag, 12);
`ifdef LOAD_QUEUE_PERF_CNT_EN
        chk("perf_fwd", perf_fwd_cnt, 2);
        chk("perf_mem", perf_mem_cnt, 1);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("p_flush_wb", wb_valid, 0);
`ifdef LOAD_QUEUE_PERF_CNT_EN
        chk("perf_fwd_flush", perf_fwd_cnt, 2);
        chk("perf_mem_flush", perf_mem_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
